// File: rtl/nibble_serializer.sv
// Parallel-to-serial stage feeding a 4-bit right-shifting register, LSB first, valid/ready input.
// Optional one-entry holding register for bubble-free frames: define NIBBLE_SER_HOLD_EN.
module nibble_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             frame_done_o,
    output logic             busy_o,
    output logic             state_dbg_o
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Handshake: a word transfers on a rising edge where in_valid_i and in_ready_o are both 1;
    // in_data_i is sampled only on that edge and must be held while in_valid_i=1 and in_ready_o=0.

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_full;
    logic             accept;
    logic             last_bit;

`ifdef NIBBLE_SER_HOLD_EN
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    assign hold_full  = hold_full_q;
    assign in_ready_o = !hold_full_q && !reset;
`else
    assign hold_full  = 1'b0;
    assign in_ready_o = (state_q == IDLE) && !reset;
`endif

    assign accept   = in_valid_i && in_ready_o;
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef NIBBLE_SER_HOLD_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in_data_i;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef NIBBLE_SER_HOLD_EN
                    if (accept) begin
                        hold_d      = in_data_i;
                        hold_full_d = 1'b1;
                    end
`endif
                end else begin
`ifdef NIBBLE_SER_HOLD_EN
                    // Chain straight into the next frame: held word first, else a bypassed accept.
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else if (accept) begin
                        shreg_d = in_data_i;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef NIBBLE_SER_HOLD_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef NIBBLE_SER_HOLD_EN
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end

    // Outputs come from registered state only, so the line is 0 whenever no frame is active.
    assign ser_out_o    = (state_q == SHIFT) && shreg_q[0];
    assign ser_valid_o  = (state_q == SHIFT);
    assign frame_done_o = last_bit;
    assign busy_o       = (state_q == SHIFT) || hold_full;
    assign state_dbg_o  = state_q;
endmodule
